// File: rtl/rv32i_run_monitor.sv
// ---------------------------------------------------------------------------
// rv32i_run_monitor
//   Run controller/monitor for the rv32i single-cycle core. It drives the
//   core's reset and watches the executing instruction and pc. A run ends
//   either on halt detection or on a cycle timeout. A small ring keeps the
//   most recent instructions for post-mortem reads.
//
// Ports
//   clk_RV        core clock, rising edge
//   reset         asynchronous, active-low
//   start         launch a run (honoured in IDLE and DONE only)
//   instruccion   instruction executing this cycle
//   pc            pc of that instruction
//   core_reset    active-high reset to rv32i (registered)
//   running       high while in RUN
//   done          run finished (sticky until the next start)
//   halted        run ended by halt detection (sticky)
//   timeout       run ended by MAX_CYCLES (sticky)
//   cycle_count   RUN cycles elapsed
//   trace_count   valid trace entries, saturates at TRACE_DEPTH
//   trace_rd_idx  trace read index, 0 = most recent instruction
//   trace_rd_data registered trace read, 1-cycle latency
// ---------------------------------------------------------------------------
module rv32i_run_monitor #(
  parameter int               WIDTH        = 32,
  parameter int               CNT_W        = 16,
  parameter int               MAX_CYCLES   = 82,
  parameter int               RESET_CYCLES = 1,
  parameter logic [WIDTH-1:0] HALT_INSTR   = WIDTH'(32'h0000_006F),
  parameter int               HALT_REPEAT  = 2,
  parameter int               TRACE_DEPTH  = 8,
  localparam int              IDX_W        = $clog2(TRACE_DEPTH),
  localparam int              TC_W         = IDX_W + 1
) (
  input  logic             clk_RV,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] instruccion,
  input  logic [WIDTH-1:0] pc,
  output logic             core_reset,
  output logic             running,
  output logic             done,
  output logic             halted,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic [TC_W-1:0]  trace_count,
  input  logic [IDX_W-1:0] trace_rd_idx,
  output logic [WIDTH-1:0] trace_rd_data
);

  // Counter widths sized so the terminal value itself is representable.
  localparam int HC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int RP_W = $clog2(HALT_REPEAT + 1);

  typedef enum logic [1:0] {IDLE, HOLD, RUN, DONE} state_e;

  state_e             state_q;
  logic [HC_W-1:0]    hold_cnt_q;
  logic [RP_W-1:0]    repeat_q;
  logic [IDX_W-1:0]   wr_ptr_q;
  logic [WIDTH-1:0]   pc_prev_q;
  logic               pc_prev_vld_q;
  logic               core_reset_q, running_q, done_q, halted_q, timeout_q;
  logic [CNT_W-1:0]   cycle_count_q;
  logic [TC_W-1:0]    trace_count_q;
  logic [WIDTH-1:0]   trace_rd_data_q;
  logic [WIDTH-1:0]   ring_q [TRACE_DEPTH];

  // Run-cycle next-state terms
  logic [CNT_W-1:0]   cycle_count_d;
  logic [RP_W-1:0]    repeat_d;
  logic               halt_cond, hit_halt, hit_tmo;
  logic [IDX_W-1:0]   rd_ptr;
  logic               rd_hit;

  always_comb begin
    cycle_count_d = cycle_count_q + CNT_W'(1);
    // pc_prev is only meaningful once a RUN cycle has been seen this run, so a
    // stale pc from the previous run cannot count toward the halt streak.
    halt_cond     = (instruccion == HALT_INSTR) ||
                    (pc_prev_vld_q && (pc == pc_prev_q));
    repeat_d      = halt_cond ? (repeat_q + RP_W'(1)) : '0;
    hit_halt      = (repeat_d == RP_W'(HALT_REPEAT));
    hit_tmo       = (cycle_count_d == CNT_W'(MAX_CYCLES));
    // wr_ptr points at the next free slot; most recent entry is wr_ptr-1.
    // IDX_W-bit arithmetic gives the modulo for free (depth is a power of 2).
    rd_ptr        = wr_ptr_q - IDX_W'(1) - trace_rd_idx;
    rd_hit        = ({1'b0, trace_rd_idx} < trace_count_q);
  end

  // Control FSM with registered outputs
  always_ff @(posedge clk_RV or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      hold_cnt_q    <= '0;
      repeat_q      <= '0;
      wr_ptr_q      <= '0;
      pc_prev_q     <= '0;
      pc_prev_vld_q <= 1'b0;
      core_reset_q  <= 1'b1;
      running_q     <= 1'b0;
      done_q        <= 1'b0;
      halted_q      <= 1'b0;
      timeout_q     <= 1'b0;
      cycle_count_q <= '0;
      trace_count_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            // Entering HOLD wipes the previous run's results.
            state_q       <= HOLD;
            hold_cnt_q    <= '0;
            repeat_q      <= '0;
            wr_ptr_q      <= '0;
            pc_prev_vld_q <= 1'b0;
            core_reset_q  <= 1'b1;
            running_q     <= 1'b0;
            done_q        <= 1'b0;
            halted_q      <= 1'b0;
            timeout_q     <= 1'b0;
            cycle_count_q <= '0;
            trace_count_q <= '0;
          end
        end
        HOLD: begin
          if (hold_cnt_q == HC_W'(RESET_CYCLES - 1)) begin
            state_q      <= RUN;
            core_reset_q <= 1'b0;
            running_q    <= 1'b1;
          end else begin
            hold_cnt_q <= hold_cnt_q + HC_W'(1);
          end
        end
        RUN: begin
          cycle_count_q <= cycle_count_d;
          wr_ptr_q      <= wr_ptr_q + IDX_W'(1);
          if (trace_count_q != TC_W'(TRACE_DEPTH))
            trace_count_q <= trace_count_q + TC_W'(1);
          repeat_q      <= repeat_d;
          pc_prev_q     <= pc;
          pc_prev_vld_q <= 1'b1;
          // Halt takes priority when both terminate on the same cycle.
          if (hit_halt || hit_tmo) begin
            state_q      <= DONE;
            core_reset_q <= 1'b1;
            running_q    <= 1'b0;
            done_q       <= 1'b1;
            halted_q     <= hit_halt;
            timeout_q    <= !hit_halt;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Trace ring storage; contents are don't-care after reset.
  always_ff @(posedge clk_RV) begin
    if (state_q == RUN)
      ring_q[wr_ptr_q] <= instruccion;
  end

  // Registered trace read; a same-cycle write to the addressed slot is not
  // visible until the following read.
  always_ff @(posedge clk_RV or negedge reset) begin
    if (!reset)
      trace_rd_data_q <= '0;
    else
      trace_rd_data_q <= rd_hit ? ring_q[rd_ptr] : '0;
  end

  assign core_reset    = core_reset_q;
  assign running       = running_q;
  assign done          = done_q;
  assign halted        = halted_q;
  assign timeout       = timeout_q;
  assign cycle_count   = cycle_count_q;
  assign trace_count   = trace_count_q;
  assign trace_rd_data = trace_rd_data_q;

endmodule

// File: tb/tb_rv32i_run_monitor.sv
// Self-checking bench for rv32i_run_monitor. Stimulus pushes expected
// run-end records and trace-read values into a queue; a monitor process pops
// and compares whenever done rises or a trace read returns.
module tb_rv32i_run_monitor;
  localparam int RC = 3;

  logic        clk_RV = 1'b0;
  logic        reset  = 1'b0;
  logic        start  = 1'b0;
  logic [31:0] instruccion = '0;
  logic [31:0] pc = '0;
  logic [2:0]  trace_rd_idx = '0;
  logic        core_reset, running, done, halted, timeout;
  logic [15:0] cycle_count;
  logic [3:0]  trace_count;
  logic [31:0] trace_rd_data;

  rv32i_run_monitor #(
    .WIDTH(32), .CNT_W(16), .MAX_CYCLES(82), .RESET_CYCLES(RC),
    .HALT_INSTR(32'h0000_006F), .HALT_REPEAT(2), .TRACE_DEPTH(8)
  ) dut (
    .clk_RV(clk_RV), .reset(reset), .start(start),
    .instruccion(instruccion), .pc(pc),
    .core_reset(core_reset), .running(running), .done(done),
    .halted(halted), .timeout(timeout), .cycle_count(cycle_count),
    .trace_count(trace_count), .trace_rd_idx(trace_rd_idx),
    .trace_rd_data(trace_rd_data)
  );

  always #5 clk_RV = ~clk_RV;

  typedef struct {
    bit          rd;
    string       nm;
    logic [31:0] data;
    logic        hlt;
    logic        tmo;
    logic [15:0] cc;
    logic [3:0]  tc;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic rd_req = 1'b0;
  logic rd_vld = 1'b0;
  logic done_d = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor
  always @(posedge clk_RV) rd_vld <= rd_req;

  always @(negedge clk_RV) begin
    if (rd_vld) begin
      if (q.size() == 0 || !q[0].rd) begin
        n_tests++; n_fail++;
        $display("FAIL sb_read: unexpected trace read data 0x%0h", trace_rd_data);
      end else begin
        chk(q[0].nm, trace_rd_data, q[0].data);
        q.delete(0);
      end
    end
    if (done && !done_d) begin
      if (q.size() == 0 || q[0].rd) begin
        n_tests++; n_fail++;
        $display("FAIL sb_done: unexpected run end, cycle_count=%0d", cycle_count);
      end else begin
        chk({q[0].nm, ".halted"},      halted,      q[0].hlt);
        chk({q[0].nm, ".timeout"},     timeout,     q[0].tmo);
        chk({q[0].nm, ".cycle_count"}, cycle_count, q[0].cc);
        chk({q[0].nm, ".trace_count"}, trace_count, q[0].tc);
        q.delete(0);
      end
    end
    done_d <= done;
  end

  // Stimulus helpers
  task automatic cyc(input logic [31:0] i, input logic [31:0] p);
    instruccion = i;
    pc          = p;
    @(posedge clk_RV); #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk_RV); #1;
    start = 1'b0;
    chk("start.trace_count_cleared", trace_count, 0);
    chk("start.done_cleared",        done,        0);
    for (int k = 0; k < RC; k++) begin
      chk($sformatf("hold%0d.core_reset", k), core_reset, 1);
      chk($sformatf("hold%0d.running", k),    running,    0);
      @(posedge clk_RV); #1;
    end
    chk("run0.running",     running,     1);
    chk("run0.core_reset",  core_reset,  0);
    chk("run0.cycle_count", cycle_count, 0);
  endtask

  task automatic push_done(input string nm, input logic h, input logic t,
                           input logic [15:0] cc, input logic [3:0] tc);
    exp_t e;
    e.rd = 1'b0; e.nm = nm; e.data = '0; e.hlt = h; e.tmo = t; e.cc = cc; e.tc = tc;
    q.push_back(e);
  endtask

  task automatic rd(input string nm, input logic [2:0] idx, input logic [31:0] exp);
    exp_t e;
    e.rd = 1'b1; e.nm = nm; e.data = exp; e.hlt = 1'b0; e.tmo = 1'b0; e.cc = '0; e.tc = '0;
    q.push_back(e);
    trace_rd_idx = idx;
    rd_req       = 1'b1;
    @(posedge clk_RV); #1;
    rd_req       = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int k = 0;
    while (!done && k < 10) begin
      @(posedge clk_RV); #1;
      k++;
    end
    chk({nm, ".done_seen"}, done, 1);
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk_RV);
    #1;
    chk("rst.core_reset",    core_reset,    1);
    chk("rst.running",       running,       0);
    chk("rst.done",          done,          0);
    chk("rst.halted",        halted,        0);
    chk("rst.timeout",       timeout,       0);
    chk("rst.cycle_count",   cycle_count,   0);
    chk("rst.trace_count",   trace_count,   0);
    chk("rst.trace_rd_data", trace_rd_data, 0);
    reset = 1'b1;
    @(posedge clk_RV); #1;
    rd("idle_empty_rd", 3'd0, 32'h0);

    // Hold timing, then reset asserted mid-run at cycle 10
    do_start();
    for (int k = 1; k <= 10; k++) begin
      cyc(32'hA000_0000 | k, 32'h0000_0000 + 4 * k);
      if (k == 1) chk("run1.cycle_count", cycle_count, 1);
    end
    chk("run10.cycle_count", cycle_count, 10);
    chk("run10.trace_count", trace_count, 8);
    #2 reset = 1'b0;
    #1;
    chk("midrst.core_reset",  core_reset,  1);
    chk("midrst.done",        done,        0);
    chk("midrst.cycle_count", cycle_count, 0);
    chk("midrst.running",     running,     0);
    chk("midrst.trace_count", trace_count, 0);
    @(posedge clk_RV); #1;
    reset = 1'b1;
    repeat (3) @(posedge clk_RV);
    #1;
    chk("idle_wait.running",    running,    0);
    chk("idle_wait.core_reset", core_reset, 1);

    // Halt on repeated 6F at constant pc
    do_start();
    push_done("halt6F", 1'b1, 1'b0, 16'd7, 4'd7);
    for (int k = 1; k <= 5; k++) cyc(32'hB000_0000 | k, 32'h100 + 4 * k);
    cyc(32'h0000_006F, 32'h200);
    cyc(32'h0000_006F, 32'h200);
    wait_done("halt6F");
    chk("halt6F.core_reset", core_reset, 1);
    chk("halt6F.running",    running,    0);
    rd("halt6F.idx0", 3'd0, 32'h0000_006F);
    rd("halt6F.idx1", 3'd1, 32'h0000_006F);
    rd("halt6F.idx2", 3'd2, 32'hB000_0005);
    rd("halt6F.idx6", 3'd6, 32'hB000_0001);
    rd("halt6F.idx7_invalid", 3'd7, 32'h0);

    // 20 distinct instructions, pc stalls on the last three -> halt at 20
    do_start();
    push_done("pcstall", 1'b1, 1'b0, 16'd20, 4'd8);
    for (int k = 1; k <= 20; k++)
      cyc(32'hC000_0000 | k, (k >= 18) ? 32'h348 : 32'h300 + 4 * k);
    wait_done("pcstall");
    for (int k = 0; k < 8; k++)
      rd($sformatf("pcstall.idx%0d", k), 3'(k), 32'hC000_0000 | (20 - k));

    // Timeout: first pc equals previous run's last pc; start pulsed mid-run
    do_start();
    push_done("timeout", 1'b0, 1'b1, 16'd82, 4'd8);
    cyc(32'hD000_0001, 32'h348);
    cyc(32'hD000_0002, 32'h348);
    for (int k = 3; k <= 82; k++) begin
      start = (k == 40);
      cyc(32'hD000_0000 | k, 32'h1000 + 4 * k);
    end
    start = 1'b0;
    wait_done("timeout");
    chk("timeout.core_reset", core_reset, 1);
    chk("timeout.running",    running,    0);
    repeat (3) cyc(32'h0, 32'h0);
    chk("timeout.done_sticky",    done,    1);
    chk("timeout.timeout_sticky", timeout, 1);
    rd("timeout.idx0", 3'd0, 32'hD000_0052);
    rd("timeout.idx7", 3'd7, 32'hD000_004B);

    // Halt streak completes on cycle 82: halt wins; lone 6F at 40 is no halt
    do_start();
    push_done("halt_at_max", 1'b1, 1'b0, 16'd82, 4'd8);
    for (int k = 1; k <= 80; k++)
      cyc((k == 40) ? 32'h0000_006F : (32'hE000_0000 | k), 32'h2000 + 4 * k);
    cyc(32'h0000_006F, 32'h3000);
    cyc(32'h0000_006F, 32'h3000);
    wait_done("halt_at_max");
    rd("halt_at_max.idx0", 3'd0, 32'h0000_006F);
    rd("halt_at_max.idx2", 3'd2, 32'hE000_0050);

    repeat (3) @(posedge clk_RV);
    #1;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d expected entries never observed", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
